sprite_loader: RTL and testbench

- Upstream feeder for a bank of N_OBJ 8x8 rectangle sprite objects.
- Accepts position, pixel-load, fill and enable commands over a valid/ready stream and turns them into per-object strobes: setxy, change_pxl, active.
- Drives the shared new_x/new_y/in buses.
- Keeps a shadow copy of each object's upper-left position, so pixel writes address the object's own 8x8 array correctly. The objects decode the write address as (new - cur) mod 8.

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_addr_gen.sv | 42 ++++
 rtl/sprite_loader.sv | 217 +++++++++++++++++++++
 tb/tb_sprite_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite loader: opcodes, FSM states and sprite geometry.
package sprite_pkg;

    localparam int COORD_W    = 10;
    localparam int RGB_W      = 24;
    localparam int SPRITE_DIM = 8;
    localparam int SPRITE_PIX = 64;
    localparam int IDX_W      = 6;

    localparam logic [1:0] OP_MOVE       = 2'd0;
    localparam logic [1:0] OP_LOAD       = 2'd1;
    localparam logic [1:0] OP_FILL       = 2'd2;
    localparam logic [1:0] OP_SET_ACTIVE = 2'd3;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_MOVE,
        ST_LOAD,
        ST_FILL
    } state_e;

endpackage

// File: rtl/sprite_addr_gen.sv
// Row-major 8x8 pixel index counter; turns the object's shadow base into bus coordinates.
module sprite_addr_gen
    import sprite_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               step_i,
    input  logic [COORD_W-1:0] base_x_i,
    input  logic [COORD_W-1:0] base_y_i,
    output logic [COORD_W-1:0] x_o,
    output logic [COORD_W-1:0] y_o,
    output logic               last_o
);

    localparam int DIM_W = $clog2(SPRITE_DIM);

    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (step_i) begin
            idx_d = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    // 10-bit wrap is intended; the objects decode the low three bits only.
    assign x_o    = base_x_i + COORD_W'(idx_q[DIM_W-1:0]);
    assign y_o    = base_y_i + COORD_W'(idx_q[IDX_W-1:DIM_W]);
    assign last_o = (idx_q == IDX_W'(SPRITE_PIX - 1));

endmodule

// File: rtl/sprite_loader.sv
// Command front end for a bank of 8x8 sprite objects: positions, pixel loads, fills, enables.
// state   | meaning
// INIT    | one-cycle setxy broadcast to park every object at (0,0)
// IDLE    | accepting commands; SET_ACTIVE and invalid objects handled here
// MOVE    | setxy strobe cycle for the moved object
// LOAD    | streaming 64 pixels from the pix handshake
// FILL    | writing 64 copies of the fill colour, one per cycle
module sprite_loader
    import sprite_pkg::*;
#(
    parameter int N_OBJ = 4,
    parameter int OBJ_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [OBJ_W-1:0]   cmd_obj,
    input  logic [COORD_W-1:0] cmd_x,
    input  logic [COORD_W-1:0] cmd_y,
    input  logic [RGB_W-1:0]   cmd_data,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [RGB_W-1:0]   pix_data,
    output logic [COORD_W-1:0] new_x,
    output logic [COORD_W-1:0] new_y,
    output logic [RGB_W-1:0]   in,
    output logic [N_OBJ-1:0]   setxy,
    output logic [N_OBJ-1:0]   change_pxl,
    output logic [N_OBJ-1:0]   active,
    output logic               busy
);

    state_e state_q, state_d;

    logic                 init_done_q, init_done_d;
    logic [OBJ_W-1:0]     obj_q, obj_d;
    logic [N_OBJ-1:0]     setxy_q, setxy_d, chg_q, chg_d, active_q, active_d;
    logic [COORD_W-1:0]   nx_q, nx_d, ny_q, ny_d;
    logic [RGB_W-1:0]     in_q, in_d;
    logic [COORD_W-1:0]   sx_q [N_OBJ];
    logic [COORD_W-1:0]   sy_q [N_OBJ];
    logic [COORD_W-1:0]   base_x, base_y, gen_x, gen_y;
    logic                 gen_last, gen_clr, gen_step;
    logic                 cmd_fire, pix_fire, obj_ok;

    function automatic logic [N_OBJ-1:0] obj_onehot(input logic [OBJ_W-1:0] idx);
        obj_onehot = '0;
        for (int k = 0; k < N_OBJ; k++) begin
            if (idx == OBJ_W'(k)) obj_onehot[k] = 1'b1;
        end
    endfunction

    assign cmd_ready = (state_q == ST_IDLE);
    assign pix_ready = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_IDLE);
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign pix_fire  = pix_valid & pix_ready;
    assign obj_ok    = (int'(cmd_obj) < N_OBJ);

    always_comb begin
        base_x = '0;
        base_y = '0;
        for (int k = 0; k < N_OBJ; k++) begin
            if (obj_q == OBJ_W'(k)) begin
                base_x = sx_q[k];
                base_y = sy_q[k];
            end
        end
    end

    assign gen_clr  = !((state_q == ST_LOAD) || (state_q == ST_FILL));
    assign gen_step = ((state_q == ST_LOAD) && pix_fire) || (state_q == ST_FILL);

    sprite_addr_gen u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (gen_clr),
        .step_i   (gen_step),
        .base_x_i (base_x),
        .base_y_i (base_y),
        .x_o      (gen_x),
        .y_o      (gen_y),
        .last_o   (gen_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (init_done_q) state_d = ST_IDLE;
            ST_IDLE: begin
                if (cmd_fire && obj_ok) begin
                    case (cmd_op)
                        OP_MOVE: state_d = ST_MOVE;
                        OP_LOAD: state_d = ST_LOAD;
                        OP_FILL: state_d = ST_FILL;
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_MOVE: state_d = ST_IDLE;
            ST_LOAD: if (pix_fire && gen_last) state_d = ST_IDLE;
            ST_FILL: if (gen_last) state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        init_done_d = init_done_q;
        obj_d       = obj_q;
        setxy_d     = '0;
        chg_d       = '0;
        active_d    = active_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        in_d        = in_q;
        case (state_q)
            ST_INIT: begin
                if (!init_done_q) begin
                    setxy_d     = '1;
                    nx_d        = '0;
                    ny_d        = '0;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (cmd_fire && obj_ok) begin
                    obj_d = cmd_obj;
                    case (cmd_op)
                        OP_MOVE: begin
                            setxy_d = obj_onehot(cmd_obj);
                            nx_d    = cmd_x;
                            ny_d    = cmd_y;
                        end
                        OP_FILL: in_d = cmd_data;
                        OP_SET_ACTIVE: begin
                            for (int k = 0; k < N_OBJ; k++) begin
                                if (cmd_obj == OBJ_W'(k)) active_d[k] = cmd_data[0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (pix_fire) begin
                    chg_d = obj_onehot(obj_q);
                    in_d  = pix_data;
                    nx_d  = gen_x;
                    ny_d  = gen_y;
                end
            end
            ST_FILL: begin
                chg_d = obj_onehot(obj_q);
                nx_d  = gen_x;
                ny_d  = gen_y;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done_q <= 1'b0;
            obj_q       <= '0;
            setxy_q     <= '0;
            chg_q       <= '0;
            active_q    <= '0;
            nx_q        <= '0;
            ny_q        <= '0;
            in_q        <= '0;
        end else begin
            init_done_q <= init_done_d;
            obj_q       <= obj_d;
            setxy_q     <= setxy_d;
            chg_q       <= chg_d;
            active_q    <= active_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            in_q        <= in_d;
        end
    end

    // Shadow copy of each object's position, written on the same edge as its setxy strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_OBJ; k++) begin
                sx_q[k] <= '0;
                sy_q[k] <= '0;
            end
        end else if ((state_q == ST_IDLE) && cmd_fire && obj_ok && (cmd_op == OP_MOVE)) begin
            for (int k = 0; k < N_OBJ; k++) begin
                if (cmd_obj == OBJ_W'(k)) begin
                    sx_q[k] <= cmd_x;
                    sy_q[k] <= cmd_y;
                end
            end
        end
    end

    assign setxy      = setxy_q;
    assign change_pxl = chg_q;
    assign active     = active_q;
    assign new_x      = nx_q;
    assign new_y      = ny_q;
    assign in         = in_q;

endmodule

// File: tb/tb_sprite_loader.sv
// Directed bench for sprite_loader: init pulse, move, load with wrap, fill, enable, mid-load reset.
module tb_sprite_loader;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_obj;
    logic [9:0]  cmd_x;
    logic [9:0]  cmd_y;
    logic [23:0] cmd_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic [9:0]  new_x;
    logic [9:0]  new_y;
    logic [23:0] in_bus;
    logic [3:0]  setxy;
    logic [3:0]  change_pxl;
    logic [3:0]  active;
    logic        busy;

    int n_vec;
    int n_miscmp;

    sprite_loader #(.N_OBJ(4), .OBJ_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_obj    (cmd_obj),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_data   (cmd_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .new_x      (new_x),
        .new_y      (new_y),
        .in         (in_bus),
        .setxy      (setxy),
        .change_pxl (change_pxl),
        .active     (active),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive a command for one accepting cycle; returns at the negedge after acceptance.
    task automatic send_cmd(input logic [1:0] op, input logic [3:0] obj,
                            input logic [9:0] x, input logic [9:0] y, input logic [23:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_obj   = obj;
        cmd_x     = x;
        cmd_y     = y;
        cmd_data  = data;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int p, cyc, nb, ns, first_s, last_s;
        bit bubble;
        n_vec     = 0;
        n_miscmp  = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_obj   = 4'd0;
        cmd_x     = 10'd0;
        cmd_y     = 10'd0;
        cmd_data  = 24'd0;
        pix_valid = 1'b0;
        pix_data  = 24'd0;

        repeat (3) @(negedge clk);
        chk("rst_setxy", setxy, 4'b0000);
        chk("rst_chg", change_pxl, 4'b0000);
        chk("rst_active", active, 4'b0000);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_pix_ready", pix_ready, 1'b0);
        chk("rst_busy", busy, 1'b1);

        rst_n = 1'b1;
        @(negedge clk);
        chk("init_setxy", setxy, 4'b1111);
        chk("init_x", new_x, 10'd0);
        chk("init_y", new_y, 10'd0);
        chk("init_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        chk("post_init_setxy", setxy, 4'b0000);
        chk("post_init_cmd_ready", cmd_ready, 1'b1);
        chk("post_init_busy", busy, 1'b0);
        chk("post_init_active", active, 4'b0000);

        send_cmd(2'd0, 4'd2, 10'd100, 10'd50, 24'd0);
        chk("move_setxy", setxy, 4'b0100);
        chk("move_x", new_x, 10'd100);
        chk("move_y", new_y, 10'd50);
        chk("move_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        chk("move_done_setxy", setxy, 4'b0000);
        chk("move_done_cmd_ready", cmd_ready, 1'b1);

        send_cmd(2'd0, 4'd1, 10'd1020, 10'd477, 24'd0);
        chk("move1_setxy", setxy, 4'b0010);
        @(negedge clk);
        send_cmd(2'd1, 4'd1, 10'd0, 10'd0, 24'd0);
        chk("load_pix_ready", pix_ready, 1'b1);
        chk("load_busy", busy, 1'b1);
        p = 0;
        cyc = 0;
        while (p < 64 && cyc < 300) begin
            bubble    = (cyc % 3 == 2);
            chk("load_pix_ready_run", pix_ready, 1'b1);
            pix_valid = !bubble;
            pix_data  = 24'h5A0000 + 24'(p);
            @(negedge clk);
            if (!bubble) begin
                chk("load_chg", change_pxl, 4'b0010);
                chk("load_in", in_bus, 24'h5A0000 + 24'(p));
                chk("load_x", new_x, 32'((1020 + p % 8) % 1024));
                chk("load_y", new_y, 32'((477 + p / 8) % 1024));
                if (p == 9) begin
                    chk("load_p9_x", new_x, 10'd1021);
                    chk("load_p9_y", new_y, 10'd478);
                end
                if (p == 63) begin
                    chk("load_p63_x", new_x, 10'd3);
                    chk("load_p63_y", new_y, 10'd484);
                    chk("load_end_busy", busy, 1'b0);
                    chk("load_end_cmd_ready", cmd_ready, 1'b1);
                end
                p++;
            end else begin
                chk("load_bubble_chg", change_pxl, 4'b0000);
            end
            cyc++;
        end
        pix_valid = 1'b0;
        chk("load_pixels_done", p, 64);
        @(negedge clk);
        chk("load_after_chg", change_pxl, 4'b0000);
        chk("load_after_pix_ready", pix_ready, 1'b0);

        send_cmd(2'd2, 4'd0, 10'd0, 10'd0, 24'hFF0000);
        nb = 0;
        ns = 0;
        first_s = -1;
        last_s = -1;
        for (int k = 0; k < 80; k++) begin
            if (busy) begin
                nb++;
                chk("fill_cmd_ready", cmd_ready, 1'b0);
            end
            if (change_pxl != 4'b0000) begin
                chk("fill_chg", change_pxl, 4'b0001);
                chk("fill_in", in_bus, 24'hFF0000);
                chk("fill_x", new_x, 32'(ns % 8));
                chk("fill_y", new_y, 32'(ns / 8));
                if (first_s < 0) first_s = k;
                last_s = k;
                ns++;
            end
            @(negedge clk);
        end
        chk("fill_busy_cycles", nb, 64);
        chk("fill_strobes", ns, 64);
        chk("fill_consecutive", last_s - first_s + 1, 64);

        send_cmd(2'd3, 4'd3, 10'd0, 10'd0, 24'h000001);
        chk("act_active", active, 4'b1000);
        chk("act_setxy", setxy, 4'b0000);
        chk("act_cmd_ready", cmd_ready, 1'b1);
        send_cmd(2'd0, 4'd7, 10'd5, 10'd6, 24'd0);
        chk("bad_obj_setxy", setxy, 4'b0000);
        chk("bad_obj_cmd_ready", cmd_ready, 1'b1);
        chk("bad_obj_x", new_x, 10'd7);
        chk("bad_obj_active", active, 4'b1000);
        @(negedge clk);
        chk("bad_obj_setxy2", setxy, 4'b0000);

        send_cmd(2'd1, 4'd2, 10'd0, 10'd0, 24'd0);
        p = 0;
        while (p < 30) begin
            pix_valid = 1'b1;
            pix_data  = 24'h00C000 + 24'(p);
            @(negedge clk);
            chk("abort_pre_chg", change_pxl, 4'b0100);
            chk("abort_pre_x", new_x, 32'(100 + p % 8));
            p++;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_chg", change_pxl, 4'b0000);
        chk("abort_active", active, 4'b0000);
        chk("abort_busy", busy, 1'b1);
        chk("abort_pix_ready", pix_ready, 1'b0);
        pix_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reinit_setxy", setxy, 4'b1111);
        chk("reinit_x", new_x, 10'd0);
        @(negedge clk);
        chk("reinit_cmd_ready", cmd_ready, 1'b1);
        chk("reinit_active", active, 4'b0000);

        send_cmd(2'd1, 4'd2, 10'd0, 10'd0, 24'd0);
        for (int q = 0; q < 2; q++) begin
            pix_valid = 1'b1;
            pix_data  = 24'h0000D0 + 24'(q);
            @(negedge clk);
            chk("reload_chg", change_pxl, 4'b0100);
            chk("reload_in", in_bus, 24'h0000D0 + 24'(q));
            chk("reload_x", new_x, 32'(q));
            chk("reload_y", new_y, 10'd0);
        end
        pix_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
